// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// Several writeback requesters share one register-file write port. A
// round-robin grant picks one valid requester per cycle, and the chosen write
// reaches the port one cycle later as a registered output. A scoreboard keeps
// one pending bit per register, so issue logic can tell when a destination
// still has a write outstanding.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [AW-1:0]     qaddr1,
  input  logic [AW-1:0]     qaddr2,
  output logic              qbusy1,
  output logic              qbusy2,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata
);

  // NREQ is limited to 2..4, so the grant index needs one or two bits.
  localparam int GW    = (NREQ > 2) ? 2 : 1;
  localparam int NPEND = 1 << AW;

  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    gnt_idx;
  logic [NREQ-1:0]  ready_raw;
  logic             found;
  int               rr_idx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             hs;

  // Register 0 never has a pending write, so only bits 1 and up are stored.
  logic [NPEND-1:1] pend_q;
  logic [NPEND-1:1] pend_next;
  logic [NPEND-1:0] pending;

  // Round-robin search starting one past the last granted requester. The
  // winner's address and data are selected here so the output register only
  // has to capture them.
  always_comb begin
    ready_raw = '0;
    found     = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[rr_idx]) begin
        found             = 1'b1;
        gnt_idx           = GW'(rr_idx);
        ready_raw[rr_idx] = 1'b1;
        sel_addr          = req_addr[rr_idx*AW +: AW];
        sel_data          = req_data[rr_idx*DW +: DW];
      end
    end
  end

  // Grants are suppressed while hold or reset is asserted.
  assign req_ready = (found && !hold && !rst) ? ready_raw : '0;
  assign hs        = |req_ready;

  // Capture the granted write for the register-file port and move the
  // round-robin pointer. Writes to register 0 still take their grant, but
  // they never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= GW'(NREQ - 1);
    end else if (hs) begin
      rf_wen     <= (sel_addr != '0);
      rf_waddr   <= sel_addr;
      rf_wdata   <= sel_data;
      last_grant <= gnt_idx;
    end else begin
      rf_wen     <= 1'b0;
    end
  end

  // Next scoreboard state. A reservation takes priority over a clear of the
  // same register, so a new producer is never lost to an older write.
  always_comb begin
    pend_next = pend_q;
    for (int i = 1; i < NPEND; i++) begin
      if (rsv_valid && (rsv_addr == AW'(i))) begin
        pend_next[i] = 1'b1;
      end else if (rf_wen && (rf_waddr == AW'(i))) begin
        pend_next[i] = 1'b0;
      end
    end
  end

  // Scoreboard storage; reset discards every reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  // Hazard queries read the stored state only, without bypassing a
  // reservation made in the same cycle.
  assign pending = {pend_q, 1'b0};
  assign qbusy1  = pending[qaddr1];
  assign qbusy2  = pending[qaddr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
// A table of per-cycle vectors drives the arbiter and scoreboard. The
// mid-stream reset case is written out by hand after the table.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NVEC = 21;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              hold;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic [AW-1:0]     qaddr1;
  logic [AW-1:0]     qaddr2;
  logic              qbusy1;
  logic              qbusy2;
  logic              rf_wen;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        hold;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [4:0]  q1, q2;
    logic [2:0]  e_ready;
    logic        e_qb1, e_qb2;
    logic        e_wen;
    logic        chk_d;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [NVEC];

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .qaddr1    (qaddr1),
    .qaddr2    (qaddr2),
    .qbusy1    (qbusy1),
    .qbusy2    (qbusy2),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [4:0] a0, a1, a2,
    input logic [31:0] d0, d1, d2, input logic h, input logic rsv,
    input logic [4:0] ra, input logic [4:0] q1, q2,
    input logic [2:0] e_ready, input logic e_qb1, e_qb2,
    input logic e_wen, input logic chk_d, input logic [4:0] e_waddr,
    input logic [31:0] e_wdata);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.hold = h; v.rsv = rsv;
    v.rsv_addr = ra; v.q1 = q1; v.q2 = q2; v.e_ready = e_ready;
    v.e_qb1 = e_qb1; v.e_qb2 = e_qb2; v.e_wen = e_wen; v.chk_d = chk_d;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    req_addr  = {v.a2, v.a1, v.a0};
    req_data  = {v.d2, v.d1, v.d0};
    hold      = v.hold;
    rsv_valid = v.rsv;
    rsv_addr  = v.rsv_addr;
    qaddr1    = v.q1;
    qaddr2    = v.q2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //          valid  a0 a1 a2  d0      d1      d2     h  r  ra q1 q2 rdy  b1 b2 wen cd waddr wdata
    vecs[0]  = mk(3'b001, 3, 0, 0, 32'h1234, 0, 0,         0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 3, 32'h1234);
    vecs[1]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 0, 3'b010, 0, 0, 1, 1, 2, 32'hA2);
    vecs[2]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 1, 3, 32'hA3);
    vecs[3]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 1, 32'hA1);
    vecs[4]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 0, 3'b010, 0, 0, 1, 1, 2, 32'hA2);
    vecs[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2, 32'hA2);
    vecs[6]  = mk(3'b010, 0, 0, 0, 0, 32'hFFFF, 0,         0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 1, 3, 32'hA3);
    vecs[8]  = mk(3'b101, 1, 0, 3, 32'hA1, 0, 32'hA3,      1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3, 32'hA3);
    vecs[9]  = mk(3'b101, 1, 0, 3, 32'hA1, 0, 32'hA3,      1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 3, 32'hA3);
    vecs[10] = mk(3'b101, 1, 0, 3, 32'hA1, 0, 32'hA3,      0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 1, 32'hA1);
    vecs[11] = mk(3'b101, 1, 0, 3, 32'hA1, 0, 32'hA3,      0, 0, 0, 0, 0, 3'b100, 0, 0, 1, 1, 3, 32'hA3);
    vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 1, 5, 5, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(3'b001, 5, 0, 0, 32'h55, 0, 0,           0, 0, 0, 5, 0, 3'b001, 1, 0, 1, 1, 5, 32'h55);
    vecs[14] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 5, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(3'b001, 5, 0, 0, 32'h66, 0, 0,           0, 1, 5, 5, 0, 3'b001, 0, 0, 1, 1, 5, 32'h66);
    vecs[17] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 1, 5, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0);
    vecs[18] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 1, 0, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(3'b000, 0, 0, 0, 0, 0, 0,                0, 0, 0, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0);

    // Reset with all requesters valid: no grant, outputs cleared.
    rst = 1'b1;
    applyStimulus(mk(3'b111, 1, 2, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_wen", 32'(rf_wen), 32'h0);
    checkOutput("reset_waddr", 32'(rf_waddr), 32'h0);
    checkOutput("reset_wdata", rf_wdata, 32'h0);
    checkOutput("reset_qbusy1", 32'(qbusy1), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    stepCycle();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("v%0d_qbusy1", i), 32'(qbusy1), 32'(vecs[i].e_qb1));
      checkOutput($sformatf("v%0d_qbusy2", i), 32'(qbusy2), 32'(vecs[i].e_qb2));
      stepCycle();
      checkOutput($sformatf("v%0d_wen", i), 32'(rf_wen), 32'(vecs[i].e_wen));
      if (vecs[i].chk_d) begin
        checkOutput($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
        checkOutput($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
      end
    end

    // Mid-stream reset: reserve 4, then 7 together with a write to 9 from
    // requester 1, so a write is in flight when reset hits.
    $display("[TB] mid-stream reset sequence");
    applyStimulus(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 7, 0, 0, 0, 0, 0, 0, 0));
    stepCycle();
    applyStimulus(mk(3'b010, 0, 9, 0, 0, 32'h99, 0, 0, 1, 7, 4, 7, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("mid_ready", 32'(req_ready), 32'h2);
    stepCycle();
    applyStimulus(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 7, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("mid_wen_pre", 32'(rf_wen), 32'h1);
    checkOutput("mid_waddr_pre", 32'(rf_waddr), 32'd9);
    checkOutput("mid_qbusy4_pre", 32'(qbusy1), 32'h1);
    checkOutput("mid_qbusy7_pre", 32'(qbusy2), 32'h1);
    rst = 1'b1;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC3, 32'hC2, 32'hC1};
    #1;
    checkOutput("mid_wen_rst", 32'(rf_wen), 32'h0);
    checkOutput("mid_qbusy4_rst", 32'(qbusy1), 32'h0);
    checkOutput("mid_qbusy7_rst", 32'(qbusy2), 32'h0);
    checkOutput("mid_ready_rst", 32'(req_ready), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
    stepCycle();
    checkOutput("post_rst_wen", 32'(rf_wen), 32'h1);
    checkOutput("post_rst_waddr", 32'(rf_waddr), 32'd1);
    checkOutput("post_rst_wdata", rf_wdata, 32'hC1);
    checkOutput("post_rst_qbusy4", 32'(qbusy1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of writeback requesters, legal range 2..4.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have parameter DW, default 32: register data width.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester write request.
REQ-007 SHALL have port req_addr  input  NREQ*AW: packed destination addresses; requester i occupies bits [i*AW +: AW].
REQ-008 SHALL have port req_data  input  NREQ*DW: packed write data; requester i occupies bits [i*DW +: DW].
REQ-009 SHALL have port req_ready  output  NREQ: one-hot grant, combinational.
REQ-010 SHALL have port hold  input  1: blocks all grants while high.
REQ-011 SHALL have port rsv_valid  input  1: reserve the destination named by rsv_addr in the scoreboard.
REQ-012 SHALL have port rsv_addr  input  AW: register being reserved.
REQ-013 SHALL have port qaddr1  input  AW and port qaddr2  input  AW: hazard query addresses.
REQ-014 SHALL have port qbusy1  output  1 and port qbusy2  output  1: the queried register has a pending write (combinational).
REQ-015 SHALL have ports rf_wen  output  1, rf_waddr  output  AW and rf_wdata  output  DW: registered drive of the register file write port.

Function
REQ-016 A handshake on requester i SHALL occur in a cycle where req_valid[i]=1 and req_ready[i]=1.
REQ-017 A requester SHALL hold req_valid, req_addr and req_data stable until its handshake; the block SHALL NOT be required to tolerate withdrawal.
REQ-018 req_ready SHALL be all-zero when hold=1 or when no req_valid is set.
REQ-019 Otherwise, exactly one req_ready bit SHALL be set, chosen round-robin: search begins at last_grant+1 modulo NREQ.
REQ-020 last_grant SHALL update to the granted index on every handshake and SHALL be unchanged otherwise.
REQ-021 On a handshake at edge N, rf_wen, rf_waddr and rf_wdata SHALL show that write from edge N until edge N+1, giving a latency of exactly 1 cycle.
REQ-022 Throughput SHALL be one write per cycle, with back-to-back grants allowed.
REQ-023 In a cycle with no handshake, rf_wen SHALL be 0 and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-024 A handshake with addr=0 SHALL be accepted (ready asserted) and SHALL advance last_grant, but SHALL produce rf_wen=0.
REQ-025 The scoreboard SHALL hold 2^AW pending bits, and bit 0 SHALL be hardwired to 0.
REQ-026 rsv_valid=1 SHALL set pending[rsv_addr] at the clock edge.
REQ-027 rf_wen=1 SHALL clear pending[rf_waddr] at the clock edge.
REQ-028 When set and clear target the same register in the same cycle, set SHALL win, so the bit stays 1.
REQ-029 qbusyK SHALL equal pending[qaddrK]; reads SHALL NOT bypass a same-cycle rsv_valid.
REQ-030 Reserving an already-pending register SHALL leave the bit at 1, with no counting.

Reset
REQ-031 While rst=1, asynchronously: rf_wen=0, rf_waddr=0, rf_wdata=0, all pending bits=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-032 req_ready SHALL be all-zero while rst=1.
REQ-033 A reset asserted mid-stream SHALL drop the in-flight output write (rf_wen forced to 0) and SHALL discard all reservations.
REQ-034 The first grant after reset release SHALL follow REQ-019 with last_grant=NREQ-1.

Verification
REQ-035 Reset then single request: req0 valid, addr=3, data=0x1234 -> req_ready=001 the same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x1234.
REQ-036 Contention: all three valid continuously, distinct addrs 1/2/3 -> grants 0,1,2,0... one per cycle; rf_waddr sequence 1,2,3 with rf_wen=1 each cycle.
REQ-037 Zero address: req1 valid, addr=0, data=0xFFFF -> req_ready=010; next cycle rf_wen=0; the next grant starts search from requester 2.
REQ-038 Hold: hold=1 with req0/req2 valid -> req_ready=000 and rf_wen=0 for every hold cycle; after release, the grant resumes at last_grant+1.
REQ-039 Scoreboard: reserve 5 -> qbusy1(qaddr1=5)=1 next cycle; grant write to 5 -> qbusy1 still 1 while rf_wen=1, then 0; repeat with rsv_valid(5) coinciding with rf_wen to 5 -> qbusy1 stays 1.
REQ-040 Mid-stream reset: assert rst during a cycle with rf_wen=1 and pending {4,7} set -> rf_wen=0 immediately, qbusy for 4 and 7 = 0, first post-reset grant goes to requester 0.
